// File: rtl/sigma_delta_front.sv
// Digital front end of the RC sigma-delta ADC.
// Synchronises the comparator, returns the 1-bit feedback to the RC integrator,
// and counts comparator ones over windows of 2^ADC_WIDTH enabled clocks.
// Each completed window's count is presented on raw_data_out with a one-cycle
// sample strobe for the downstream box averager.
module sigma_delta_front #(
    parameter int ADC_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 analog_cmp,
    output logic                 analog_out,
    output logic [ADC_WIDTH-1:0] raw_data_out,
    output logic                 sample,
    output logic                 clip
);

    // A full window of ones reaches 2^ADC_WIDTH, one more than raw_data_out can show.
    localparam logic [ADC_WIDTH:0]   FULL_COUNT = {1'b1, {ADC_WIDTH{1'b0}}};
    localparam logic [ADC_WIDTH-1:0] MAX_CODE   = {ADC_WIDTH{1'b1}};

    logic                 cmpS1_q;
    logic                 cmpS2_q;
    logic                 analogOut_q;
    logic [ADC_WIDTH-1:0] wcnt_q;
    logic [ADC_WIDTH-1:0] wcnt_d;
    logic [ADC_WIDTH:0]   acc_q;
    logic [ADC_WIDTH:0]   acc_d;
    logic [ADC_WIDTH:0]   total;
    logic                 terminal;
    logic [ADC_WIDTH-1:0] rawData_q;
    logic [ADC_WIDTH-1:0] rawData_d;
    logic                 sample_q;
    logic                 sample_d;
    logic                 clip_q;
    logic                 clip_d;

    // Two-flop synchroniser; the feedback bit is taken from the first stage so it
    // lines up with the second stage, two clocks after the raw comparator.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmpS1_q     <= 1'b0;
            cmpS2_q     <= 1'b0;
            analogOut_q <= 1'b0;
        end else begin
            cmpS1_q     <= analog_cmp;
            cmpS2_q     <= cmpS1_q;
            analogOut_q <= cmpS1_q;
        end
    end

    // Window sequencing: the terminal edge folds its own bit into the result and
    // restarts the accumulator at zero, so no bit is lost or counted twice.
    // Dropping enable discards the partial window and holds the last result.
    always_comb begin
        total     = acc_q + {{ADC_WIDTH{1'b0}}, cmpS2_q};
        terminal  = (wcnt_q == MAX_CODE);
        wcnt_d    = '0;
        acc_d     = '0;
        rawData_d = rawData_q;
        clip_d    = clip_q;
        sample_d  = 1'b0;
        if (enable) begin
            wcnt_d = wcnt_q + 1'b1;
            if (terminal) begin
                acc_d    = '0;
                sample_d = 1'b1;
                if (total == FULL_COUNT) begin
                    rawData_d = MAX_CODE;
                    clip_d    = 1'b1;
                end else begin
                    rawData_d = total[ADC_WIDTH-1:0];
                    clip_d    = 1'b0;
                end
            end else begin
                acc_d = total;
            end
        end
    end

    // Window counter, accumulator and registered result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wcnt_q    <= '0;
            acc_q     <= '0;
            rawData_q <= '0;
            sample_q  <= 1'b0;
            clip_q    <= 1'b0;
        end else begin
            wcnt_q    <= wcnt_d;
            acc_q     <= acc_d;
            rawData_q <= rawData_d;
            sample_q  <= sample_d;
            clip_q    <= clip_d;
        end
    end

    assign analog_out   = analogOut_q;
    assign raw_data_out = rawData_q;
    assign sample       = sample_q;
    assign clip         = clip_q;

endmodule
